// File: rtl/i2s_tdm_transmitter_pkg.sv
// Shared mode encodings and frame-geometry helper for the serial audio transmitter.
package i2s_pkg;
  localparam logic [1:0] MODE_I2S = 2'b00;
  localparam logic [1:0] MODE_LJ  = 2'b01;
  localparam logic [1:0] MODE_TDM = 2'b10;

  function automatic int frame_bit_count(input int channels, input int slot_width);
    return channels * slot_width;
  endfunction
endpackage

// File: rtl/i2s_tdm_transmitter_fifo.sv
// Frame FIFO with registered full/empty flags; read data is show-ahead so a frame is usable on the pop cycle.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             do_push, do_pop;

  // Pop only sees what was stored before this cycle, so a push into an empty FIFO is never popped at once.
  assign do_pop  = pop && !empty_reg;
  assign do_push = push && !full_reg;

  always_comb begin
    count_next = count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == (AW+1)'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;
endmodule

// File: rtl/i2s_tdm_transmitter.sv
// I2S / left-justified / TDM (DSP-A) serializer with sclk/lrclk generation and a frame FIFO on the input.
module i2s_tdm_transmitter
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int CHANNELS     = 2,
  parameter int CLK_DIV      = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             enable,
  input  logic [1:0]                       mode,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] s_data,
  output logic                             underrun,
  input  logic                             underrun_clr,
  output logic                             frame_start,
  output logic                             sclk,
  output logic                             lrclk,
  output logic                             sd
);
  localparam int FRAME_BITS = frame_bit_count(CHANNELS, SLOT_WIDTH);
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DATA_W     = CHANNELS * SAMPLE_WIDTH;

  logic [DATA_W-1:0]     fifo_dout;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [FRAME_BITS-1:0] frame_vec;

  logic                  running_reg, running_next;
  logic [1:0]            mode_reg, mode_next, cur_mode;
  logic [DIV_W-1:0]      div_reg, div_next;
  logic                  sclk_reg, sclk_next;
  logic [BIT_W-1:0]      bit_reg, bit_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic                  lj_bit_reg, lj_bit_next;
  logic                  sd_reg, sd_next;
  logic                  lrclk_reg, lrclk_next;
  logic                  frame_start_reg, frame_start_next;
  logic                  underrun_reg, underrun_next;
  logic                  load, advance, new_bit, is_lj, is_tdm;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (s_valid),
    .pop   (fifo_pop),
    .din   (s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign s_ready = !fifo_full;

  // Slot n sits MSB-first at frame position n*SLOT_WIDTH; an empty FIFO yields a silent frame.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slot
    assign frame_vec[FRAME_BITS-1-gi*SLOT_WIDTH -: SLOT_WIDTH] = fifo_empty ? '0 :
        (SLOT_WIDTH'(fifo_dout[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH]) << (SLOT_WIDTH - SAMPLE_WIDTH));
  end

  always_comb begin
    cur_mode = running_reg ? mode_reg : mode;
    is_lj    = 1'b0;
    is_tdm   = 1'b0;
    case (cur_mode)
      MODE_LJ:  is_lj  = 1'b1;
      MODE_TDM: is_tdm = 1'b1;
      MODE_I2S: is_lj  = 1'b0;
      default:  is_lj  = 1'b0;
    endcase

    running_next     = running_reg;
    mode_next        = mode_reg;
    div_next         = div_reg;
    sclk_next        = sclk_reg;
    bit_next         = bit_reg;
    shift_next       = shift_reg;
    lj_bit_next      = lj_bit_reg;
    sd_next          = sd_reg;
    lrclk_next       = lrclk_reg;
    frame_start_next = 1'b0;
    load             = 1'b0;
    advance          = 1'b0;
    new_bit          = 1'b0;

    if (!enable) begin
      running_next = 1'b0;
      div_next     = '0;
      sclk_next    = 1'b0;
      bit_next     = '0;
      lj_bit_next  = 1'b0;
      sd_next      = 1'b0;
      lrclk_next   = 1'b0;
    end else if (!running_reg) begin
      running_next = 1'b1;
      mode_next    = mode;
      div_next     = '0;
      bit_next     = '0;
      load         = 1'b1;
    end else if (div_reg == DIV_W'(CLK_DIV - 1)) begin
      div_next  = '0;
      sclk_next = !sclk_reg;
      // Data and word select move only on the falling sclk edge.
      if (sclk_reg) begin
        if (bit_reg == BIT_W'(FRAME_BITS - 1)) begin
          bit_next = '0;
          load     = 1'b1;
        end else begin
          bit_next = bit_reg + 1'b1;
          advance  = 1'b1;
        end
      end
    end else begin
      div_next = div_reg + 1'b1;
    end

    if (load) begin
      shift_next       = frame_vec;
      new_bit          = frame_vec[FRAME_BITS-1];
      frame_start_next = 1'b1;
    end else if (advance) begin
      shift_next = shift_reg << 1;
      new_bit    = shift_reg[FRAME_BITS-2];
    end

    if (load || advance) begin
      lj_bit_next = new_bit;
      // I2S and TDM replay the left-justified stream one bit period late.
      sd_next     = is_lj ? new_bit : lj_bit_reg;
      lrclk_next  = is_tdm ? (bit_next == BIT_W'(FRAME_BITS - 1))
                           : (bit_next < BIT_W'(FRAME_BITS / 2));
    end

    fifo_pop      = load && !fifo_empty;
    underrun_next = (load && fifo_empty) ? 1'b1 : (underrun_clr ? 1'b0 : underrun_reg);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      running_reg     <= 1'b0;
      mode_reg        <= MODE_I2S;
      div_reg         <= '0;
      sclk_reg        <= 1'b0;
      bit_reg         <= '0;
      shift_reg       <= '0;
      lj_bit_reg      <= 1'b0;
      sd_reg          <= 1'b0;
      lrclk_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      running_reg     <= running_next;
      mode_reg        <= mode_next;
      div_reg         <= div_next;
      sclk_reg        <= sclk_next;
      bit_reg         <= bit_next;
      shift_reg       <= shift_next;
      lj_bit_reg      <= lj_bit_next;
      sd_reg          <= sd_next;
      lrclk_reg       <= lrclk_next;
      frame_start_reg <= frame_start_next;
      underrun_reg    <= underrun_next;
    end
  end

  assign sclk        = sclk_reg;
  assign lrclk       = lrclk_reg;
  assign sd          = sd_reg;
  assign frame_start = frame_start_reg;
  assign underrun    = underrun_reg;
endmodule

// File: tb/tb_i2s_tdm_transmitter.sv
// Scoreboard bench: a 2-channel instance covers LJ/I2S/backpressure/underrun/abort, a 4-channel one covers TDM.
module tb_i2s_tdm_transmitter;
  import i2s_pkg::*;

  typedef struct {
    logic [31:0] sd_w;
    logic [31:0] lr_w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  mode = MODE_LJ;
  logic        underrun_clr = 1'b0;
  logic        sel = 1'b0;

  logic        enable_a = 1'b0, s_valid_a = 1'b0;
  logic [47:0] s_data_a = '0;
  logic        s_ready_a, underrun_a, frame_start_a, sclk_a, lrclk_a, sd_a;

  logic        enable_b = 1'b0, s_valid_b = 1'b0;
  logic [95:0] s_data_b = '0;
  logic        s_ready_b, underrun_b, frame_start_b, sclk_b, lrclk_b, sd_b;

  logic        mon_sclk, mon_sd, mon_lr, mon_fs, mon_ur;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  logic        prev_lsb = 1'b0;

  always #5 clk = ~clk;

  i2s_tdm_transmitter #(.CLK_DIV(2)) dut_a (
    .clk(clk), .rstn(rstn), .enable(enable_a), .mode(mode),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
    .underrun(underrun_a), .underrun_clr(underrun_clr), .frame_start(frame_start_a),
    .sclk(sclk_a), .lrclk(lrclk_a), .sd(sd_a)
  );

  i2s_tdm_transmitter #(.CHANNELS(4), .CLK_DIV(2)) dut_b (
    .clk(clk), .rstn(rstn), .enable(enable_b), .mode(mode),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
    .underrun(underrun_b), .underrun_clr(underrun_clr), .frame_start(frame_start_b),
    .sclk(sclk_b), .lrclk(lrclk_b), .sd(sd_b)
  );

  assign mon_sclk = sel ? sclk_b : sclk_a;
  assign mon_sd   = sel ? sd_b : sd_a;
  assign mon_lr   = sel ? lrclk_b : lrclk_a;
  assign mon_fs   = sel ? frame_start_b : frame_start_a;
  assign mon_ur   = sel ? underrun_b : underrun_a;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rand48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  // Expected slot words: LJ puts the sample MSB on slot bit 0; I2S/TDM carry the whole stream one bit late.
  task automatic model_frame(input logic [1:0] m, input int nch, input logic [95:0] data);
    exp_t        e;
    logic [31:0] w;
    for (int s = 0; s < nch; s++) begin
      w = {data[s*24 +: 24], 8'h00};
      e.sd_w = (m == MODE_LJ) ? w : {prev_lsb, w[31:1]};
      prev_lsb = w[0];
      if (m == MODE_TDM) e.lr_w = (s == nch - 1) ? 32'h1 : 32'h0;
      else               e.lr_w = (s < nch / 2) ? 32'hFFFF_FFFF : 32'h0;
      sb_q.push_back(e);
    end
  endtask

  task automatic push_frame(input logic [1:0] m, input logic [95:0] data);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (sel) begin s_valid_b = 1'b1; s_data_b = data;        ok = s_ready_b; end
      else     begin s_valid_a = 1'b1; s_data_a = data[47:0];  ok = s_ready_a; end
      step();
    end
    s_valid_a = 1'b0;
    s_valid_b = 1'b0;
    check("push_accept", 64'(ok), 64'd1);
    model_frame(m, sel ? 4 : 2, data);
  endtask

  task automatic wait_rise();
    logic prev, hit;
    prev = mon_sclk;
    hit  = 1'b0;
    for (int c = 0; c < 64 && !hit; c++) begin
      step();
      if (!prev && mon_sclk) hit = 1'b1;
      prev = mon_sclk;
    end
    if (!hit) check("rise_timeout", 64'(hit), 64'd1);
  endtask

  task automatic check_slots(input int n);
    logic [31:0] sdw, lrw;
    exp_t        e;
    for (int s = 0; s < n; s++) begin
      sdw = '0;
      lrw = '0;
      for (int b = 0; b < 32; b++) begin
        wait_rise();
        sdw = {sdw[30:0], mon_sd};
        lrw = {lrw[30:0], mon_lr};
      end
      check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sd_slot", 64'(sdw), 64'(e.sd_w));
        check("lr_slot", 64'(lrw), 64'(e.lr_w));
      end
      $display("slot dut=%0d sd=%h lr=%h", sel, sdw, lrw);
    end
  endtask

  task automatic stop_a();
    enable_a = 1'b0;
    step();
    check("idle_a", 64'({sclk_a, lrclk_a, sd_a}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          accepted;
    logic        ok;
    logic [47:0] cur;

    // Reset state
    step(); step();
    check("reset_state", 64'({s_ready_a, sclk_a, lrclk_a, sd_a, underrun_a, frame_start_a}), 64'b100000);
    rstn = 1'b1;
    step();

    // Left-justified
    mode = MODE_LJ; sel = 1'b0; prev_lsb = 1'b0;
    push_frame(MODE_LJ, {48'h0, 24'h5A5A5A, 24'hA5A5A5});
    enable_a = 1'b1;
    step();
    check("lj_frame_start", 64'({mon_fs, mon_ur, mon_sd}), 64'b101);
    check_slots(2);
    stop_a();
    check("lj_no_underrun", 64'(underrun_a), 64'd0);

    // I2S
    mode = MODE_I2S; prev_lsb = 1'b0;
    push_frame(MODE_I2S, {48'h0, 24'h5A5A5A, 24'hA5A5A5});
    enable_a = 1'b1;
    step();
    check("i2s_bit0", 64'({mon_fs, mon_sd, mon_lr}), 64'b101);
    check_slots(2);
    stop_a();

    // TDM on the 4-channel instance
    mode = MODE_TDM; sel = 1'b1; prev_lsb = 1'b0;
    push_frame(MODE_TDM, {24'h444444, 24'h333333, 24'h222222, 24'h111111});
    enable_b = 1'b1;
    step();
    check("tdm_frame_start", 64'({mon_fs, mon_lr}), 64'b10);
    check_slots(4);
    enable_b = 1'b0;
    step();
    check("idle_b", 64'({sclk_b, lrclk_b, sd_b}), 64'd0);

    // Backpressure with the serializer stopped
    mode = MODE_I2S; sel = 1'b0; prev_lsb = 1'b0;
    accepted = 0;
    cur = rand48();
    for (int c = 0; c < 8; c++) begin
      s_valid_a = 1'b1;
      s_data_a  = cur;
      ok = s_ready_a;
      step();
      if (ok) begin
        accepted++;
        model_frame(MODE_I2S, 2, {48'h0, cur});
        if (accepted == 4) check("bp_ready_next", 64'(s_ready_a), 64'd0);
        cur = rand48();
      end
    end
    s_valid_a = 1'b0;
    check("bp_accepts", 64'(accepted), 64'd4);
    enable_a = 1'b1;
    step();
    check("bp_ready_after_pop", 64'({s_ready_a, frame_start_a}), 64'b11);
    check_slots(8);
    stop_a();
    check("bp_no_underrun", 64'(underrun_a), 64'd0);

    // Underrun from an empty FIFO; clear and set collide at the second load
    model_frame(MODE_I2S, 2, 96'h0);
    enable_a = 1'b1;
    step();
    check("ur_first_load", 64'({frame_start_a, underrun_a}), 64'b11);
    check_slots(2);
    step();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("ur_set_beats_clr", 64'({frame_start_a, underrun_a}), 64'b11);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("ur_cleared", 64'(underrun_a), 64'd0);
    stop_a();

    // Abort mid-frame at bit 40, then resume with the next queued frame
    mode = MODE_LJ; prev_lsb = 1'b0;
    push_frame(MODE_LJ, {48'h0, rand48()});
    push_frame(MODE_LJ, {48'h0, rand48()});
    enable_a = 1'b1;
    step();
    check_slots(1);
    for (int b = 0; b < 9; b++) wait_rise();
    void'(sb_q.pop_front());
    stop_a();
    check("abort_fifo_kept", 64'(s_ready_a), 64'd1);
    enable_a = 1'b1;
    step();
    check("resume_start", 64'({frame_start_a, underrun_a}), 64'b10);
    check_slots(2);
    stop_a();

    // Reset mid-frame at bit 10 with enable held high
    push_frame(MODE_LJ, {48'h0, rand48()});
    enable_a = 1'b1;
    step();
    for (int b = 0; b < 11; b++) wait_rise();
    rstn = 1'b0;
    step();
    check("midreset_state", 64'({s_ready_a, sclk_a, lrclk_a, sd_a, underrun_a, frame_start_a}), 64'b100000);
    sb_q.delete();
    rstn = 1'b1;
    step();
    check("midreset_flushed", 64'({frame_start_a, underrun_a}), 64'b11);
    stop_a();

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
